// File: rtl/root_power_loader.sv
// Streams twiddle beats (W and Shoup WQ) into per-stage root-power banks:
// beats fill a row lane by lane, each full row is written to its stage's bank.
module root_power_loader #(
  parameter  int FSIZE = 64,
  parameter  int E     = 8,
  parameter  int logE  = 3,
  parameter  int N     = 4096,
  localparam int L     = E / 2,
  localparam int R     = N / L,
  localparam int AW    = (R > 1) ? $clog2(R) : 1
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic                                 abort,
  output logic                                 busy,
  output logic                                 done,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [FSIZE-1:0]                     s_w,
  input  logic [FSIZE-1:0]                     s_wq,
  output logic [logE-1:0][AW-1:0]              w_waddr,
  output logic [logE-1:0][AW-1:0]              wq_waddr,
  output logic [logE-1:0][L-1:0][FSIZE-1:0]    w_wdata,
  output logic [logE-1:0][L-1:0][FSIZE-1:0]    wq_wdata,
  output logic [logE-1:0][L-1:0]               w_wren,
  output logic [logE-1:0][L-1:0]               wq_wren
);

  localparam int LW = (L > 1) ? $clog2(L) : 1;
  localparam int SW = (logE > 1) ? $clog2(logE) : 1;
  localparam logic [LW-1:0] LANE_MAX  = LW'(L - 1);
  localparam logic [AW-1:0] ROW_MAX   = AW'(R - 1);
  localparam logic [SW-1:0] STAGE_MAX = SW'(logE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e                           state_q;
  logic [LW-1:0]                    lane_q;
  logic [AW-1:0]                    row_q;
  logic [SW-1:0]                    stage_q;
  logic [L-1:0][FSIZE-1:0]          w_buf_q, wq_buf_q;
  logic [L-1:0][FSIZE-1:0]          w_row, wq_row;
  logic                             done_q;
  logic [logE-1:0][L-1:0]           wren_q;
  logic [logE-1:0][AW-1:0]          waddr_q;
  logic [logE-1:0][L-1:0][FSIZE-1:0] w_wdata_q, wq_wdata_q;
  logic                             acc;

  assign s_ready = (state_q == LOAD) && !abort;
  assign acc     = s_valid && s_ready;

  // The completing beat bypasses the buffer so its row is written the next cycle.
  always_comb begin
    w_row          = w_buf_q;
    wq_row         = wq_buf_q;
    w_row[lane_q]  = s_w;
    wq_row[lane_q] = s_wq;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      row_q      <= '0;
      stage_q    <= '0;
      w_buf_q    <= '0;
      wq_buf_q   <= '0;
      done_q     <= 1'b0;
      wren_q     <= '0;
      waddr_q    <= '0;
      w_wdata_q  <= '0;
      wq_wdata_q <= '0;
    end else begin
      wren_q <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            lane_q  <= '0;
            row_q   <= '0;
            stage_q <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            state_q <= IDLE;
            lane_q  <= '0;
            row_q   <= '0;
            stage_q <= '0;
          end else if (acc) begin
            w_buf_q[lane_q]  <= s_w;
            wq_buf_q[lane_q] <= s_wq;
            if (lane_q == LANE_MAX) begin
              lane_q              <= '0;
              wren_q[stage_q]     <= '1;
              waddr_q[stage_q]    <= row_q;
              w_wdata_q[stage_q]  <= w_row;
              wq_wdata_q[stage_q] <= wq_row;
              if (row_q == ROW_MAX) begin
                row_q <= '0;
                if (stage_q == STAGE_MAX) begin
                  stage_q <= '0;
                  state_q <= DONE;
                  done_q  <= 1'b1;
                end else begin
                  stage_q <= stage_q + 1'b1;
                end
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              lane_q <= lane_q + 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign w_wren   = wren_q;
  assign wq_wren  = wren_q;
  assign w_waddr  = waddr_q;
  assign wq_waddr = waddr_q;
  assign w_wdata  = w_wdata_q;
  assign wq_wdata = wq_wdata_q;

endmodule

// File: tb/tb_root_power_loader.sv
// Directed bench for root_power_loader at N=16, E=4, logE=2 (L=2, R=8, 32 beats).
module tb_root_power_loader;
  localparam int FSIZE = 16, E = 4, LOGE = 2, N = 16;
  localparam int L = E / 2, R = N / L, AW = 3;

  logic clk = 1'b0, rstn = 1'b0;
  logic start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic busy, done, s_ready;
  logic [FSIZE-1:0] s_w = '0, s_wq = '0;
  logic [LOGE-1:0][AW-1:0]           w_waddr, wq_waddr;
  logic [LOGE-1:0][L-1:0][FSIZE-1:0] w_wdata, wq_wdata;
  logic [LOGE-1:0][L-1:0]            w_wren, wq_wren;

  root_power_loader #(.FSIZE(FSIZE), .E(E), .logE(LOGE), .N(N)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_w(s_w), .s_wq(s_wq),
    .w_waddr(w_waddr), .wq_waddr(wq_waddr), .w_wdata(w_wdata), .wq_wdata(wq_wdata),
    .w_wren(w_wren), .wq_wren(wq_wren)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int acc_cyc[$], done_cyc[$], wr_cyc[$];
  logic [7:0]  wr_en[$];
  logic [5:0]  wr_addr[$];
  logic [31:0] wr_w[$], wr_wq[$];

  always @(posedge clk) begin
    if (s_valid && s_ready) acc_cyc.push_back(cyc);
    cyc++;
  end

  // Record every presented write; the stage is the one whose enables are set.
  always @(negedge clk) begin
    int s;
    if (w_wren != '0 || wq_wren != '0) begin
      s = (w_wren[1] != '0) ? 1 : 0;
      wr_en.push_back({wq_wren, w_wren});
      wr_addr.push_back({wq_waddr[s], w_waddr[s]});
      wr_w.push_back(w_wdata[s]);
      wr_wq.push_back(wq_wdata[s]);
      wr_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    acc_cyc.delete(); done_cyc.delete(); wr_cyc.delete();
    wr_en.delete(); wr_addr.delete(); wr_w.delete(); wr_wq.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beats(input int from, input int to, input int wb, input int wqb, input bit gap);
    for (int i = from; i <= to; i++) begin
      s_valid = 1'b1;
      s_w  = FSIZE'(wb + i);
      s_wq = FSIZE'(wqb + i);
      @(negedge clk);
      if (gap) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
  endtask

  // Full 32-beat load with s_w=i, s_wq=100+i: write j -> stage j/8, row j%8.
  task automatic check_run(input string tag);
    logic [3:0] en;
    logic [15:0] lo, hi;
    chk({tag, ".nwr"}, wr_w.size(), 16);
    chk({tag, ".nacc"}, acc_cyc.size(), 32);
    for (int j = 0; j < 16; j++) begin
      if (j < wr_w.size()) begin
        en = (j < 8) ? 4'b0011 : 4'b1100;
        lo = 16'(2 * j);
        hi = 16'(2 * j + 1);
        chk($sformatf("%s.en%0d", tag, j), wr_en[j], {en, en});
        chk($sformatf("%s.addr%0d", tag, j), wr_addr[j], {3'(j % 8), 3'(j % 8)});
        chk($sformatf("%s.w%0d", tag, j), wr_w[j], {hi, lo});
        chk($sformatf("%s.wq%0d", tag, j), wr_wq[j], {hi + 16'd100, lo + 16'd100});
        if (acc_cyc.size() > 2 * j + 1)
          chk($sformatf("%s.t%0d", tag, j), wr_cyc[j], acc_cyc[2 * j + 1] + 1);
      end
    end
    chk({tag, ".ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0 && wr_cyc.size() > 0)
      chk({tag, ".tdone"}, done_cyc[0], wr_cyc[wr_cyc.size() - 1]);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.ready", s_ready, 0);
    chk("rst.wren", {wq_wren, w_wren}, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Back-to-back load
    clear_log();
    pulse_start();
    chk("b2b.busy", busy, 1);
    beats(0, 31, 0, 100, 1'b0);
    chk("b2b.done", done, 1);
    chk("b2b.busyd", busy, 1);
    @(negedge clk);
    chk("b2b.idle", busy, 0);
    chk("b2b.done0", done, 0);
    chk("b2b.wren0", {wq_wren, w_wren}, 0);
    chk("b2b.hold", w_waddr[1], 7);
    @(negedge clk);
    check_run("b2b");

    // Gapped valid
    clear_log();
    pulse_start();
    beats(0, 31, 0, 100, 1'b1);
    @(negedge clk);
    check_run("gap");

    // Abort with a partial row pending
    clear_log();
    pulse_start();
    beats(0, 2, 0, 100, 1'b0);
    abort = 1'b1; s_valid = 1'b1; s_w = 16'd3; s_wq = 16'd103;
    #1 chk("abt.ready", s_ready, 0);
    @(negedge clk);
    abort = 1'b0; s_valid = 1'b0;
    chk("abt.idle", busy, 0);
    repeat (2) @(negedge clk);
    chk("abt.nwr", wr_w.size(), 1);
    chk("abt.nacc", acc_cyc.size(), 3);
    chk("abt.ndone", done_cyc.size(), 0);
    if (wr_w.size() > 0) begin
      chk("abt.en", wr_en[0], 8'h33);
      chk("abt.addr", wr_addr[0], 0);
      chk("abt.w", wr_w[0], {16'd1, 16'd0});
    end
    pulse_start();
    beats(0, 1, 200, 300, 1'b0);
    @(negedge clk);
    chk("abt2.nwr", wr_w.size(), 2);
    if (wr_w.size() > 1) begin
      chk("abt2.en", wr_en[1], 8'h33);
      chk("abt2.addr", wr_addr[1], 0);
      chk("abt2.w", wr_w[1], {16'd201, 16'd200});
      chk("abt2.wq", wr_wq[1], {16'd301, 16'd300});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abt2.idle", busy, 0);

    // Valid in IDLE, start+abort in IDLE, start during LOAD
    clear_log();
    s_valid = 1'b1; s_w = 16'd77;
    #1 chk("idle.ready", s_ready, 0);
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    chk("idle.nacc", acc_cyc.size(), 0);
    chk("idle.busy", busy, 0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa.busy", busy, 1);
    beats(0, 2, 0, 100, 1'b0);
    start = 1'b1;
    beats(3, 3, 0, 100, 1'b0);
    start = 1'b0;
    beats(4, 31, 0, 100, 1'b0);
    repeat (2) @(negedge clk);
    check_run("sload");

    // Reset mid-load at beat 17
    clear_log();
    pulse_start();
    beats(0, 16, 0, 100, 1'b0);
    s_valid = 1'b1; s_w = 16'd17; s_wq = 16'd117;
    rstn = 1'b0;
    #1;
    chk("mrst.busy", busy, 0);
    chk("mrst.done", done, 0);
    chk("mrst.ready", s_ready, 0);
    chk("mrst.wren", {wq_wren, w_wren}, 0);
    chk("mrst.waddr", {wq_waddr, w_waddr}, 0);
    chk("mrst.wdata", w_wdata, 0);
    chk("mrst.wqdata", wq_wdata, 0);
    @(negedge clk);
    rstn = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    clear_log();
    pulse_start();
    beats(0, 31, 0, 100, 1'b0);
    repeat (2) @(negedge clk);
    check_run("rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
